sram_pattern_writer: RTL and testbench

SRAM_PATTERN_WRITER -- requirements
Module: sram_pattern_writer

---
 rtl/sram_pkg.sv | 39 +++
 rtl/sram_pattern_writer.sv | 211 +++++++++++++++++++++
 tb/tb_sram_pattern_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: definitions shared by the SRAM pattern writer and the existing
// SRAM reader.
//   sram_state_t  - sequencer states. RSETUP/RCMP exist only when
//                   SRAM_WRITE_VERIFY_EN is defined.
//   WORDS_PER_BAR - 16-bit SRAM words per 64-bit bar pattern.
//   LAYER_OFFSET  - word offset applied to layer-1 bars.
//   bar_base()    - first SRAM word address of a bar in a given layer.
package sram_pkg;

  localparam int unsigned WORDS_PER_BAR = 4;
  localparam int unsigned LAYER_OFFSET  = 64;
  localparam int unsigned ADDR_W        = 20;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETUP,
    PULSE,
    HOLD,
    DONE
`ifdef SRAM_WRITE_VERIFY_EN
    ,
    RSETUP,
    RCMP
`endif
  } sram_state_t;

  // Bar 0 starts one bar in, so bar b begins at (b+1)*words_per_bar.
  // The sum is formed at 32 bits and then narrowed to the 20-bit address.
  function automatic logic [ADDR_W-1:0] bar_base(input logic [3:0]  bar,
                                                 input logic        layer,
                                                 input int unsigned words_per_bar,
                                                 input int unsigned layer_offset);
    logic [31:0] sum;
    sum = (32'(bar) + 32'd1) * words_per_bar + (layer ? layer_offset : 32'd0);
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sram_pattern_writer.sv
// sram_pattern_writer: writes one 64-bit bar pattern into an asynchronous
// 16-bit SRAM as WORDS_PER_BAR consecutive words, with a
// SETUP -> PULSE -> HOLD cycle per word. All SRAM-facing outputs are
// registered from the next-state decode, so they are glitch-free and reset
// drives them to their idle values asynchronously.
//
// Optional feature: define SRAM_WRITE_VERIFY_EN to add a readback pass
// (RSETUP/RCMP per word) that compares each word and flags o_err.
//
// Ports
//   i_bclk      clock
//   i_rst       asynchronous active-low reset
//   i_mode      write-mode enable; low aborts any job and returns to IDLE
//   i_start     write request, accepted only in ARMED
//   i_bar       bar index (0..15)
//   i_layer     layer select (adds LAYER_OFFSET to the base address)
//   i_data      64-bit bar pattern, word k = i_data[16k+15:16k]
//   i_SRAM_DQ   SRAM read data (verify builds only)
//   o_addr      SRAM word address
//   o_SRAM_DQ   SRAM write data
//   o_dq_oe     DQ drive enable
//   o_we_n      SRAM write strobe, low for one cycle per word
//   o_oe_n      SRAM output enable (tied high without verify)
//   o_busy      high in every state except IDLE and ARMED
//   o_finish    one-cycle completion pulse
//   o_err       readback mismatch for the last job (tied low without verify)
module sram_pattern_writer
  import sram_pkg::*;
#(
  parameter int unsigned LAYER_OFFSET  = sram_pkg::LAYER_OFFSET,
  parameter int unsigned WORDS_PER_BAR = sram_pkg::WORDS_PER_BAR
) (
  input  logic        i_bclk,
  input  logic        i_rst,
  input  logic        i_mode,
  input  logic        i_start,
  input  logic [3:0]  i_bar,
  input  logic        i_layer,
  input  logic [63:0] i_data,
  input  logic [15:0] i_SRAM_DQ,
  output logic [19:0] o_addr,
  output logic [15:0] o_SRAM_DQ,
  output logic        o_dq_oe,
  output logic        o_we_n,
  output logic        o_oe_n,
  output logic        o_busy,
  output logic        o_finish,
  output logic        o_err
);

  localparam int unsigned KW = (WORDS_PER_BAR > 1) ? $clog2(WORDS_PER_BAR) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(WORDS_PER_BAR - 1);

  sram_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    bar_q, bar_d;
  logic          layer_q, layer_d;
  logic [63:0]   data_q, data_d;

  logic [19:0]   addr_d;
  logic [15:0]   dq_d;
  logic          dq_oe_d;
  logic          we_n_d;
  logic          busy_d;
  logic          finish_d;
  logic          write_ph;
  logic          addr_en;

`ifdef SRAM_WRITE_VERIFY_EN
  logic          err_q, err_d;
  logic          oe_n_d;
  logic          read_ph;
`endif

  function automatic logic [15:0] word_of(input logic [63:0] d, input logic [KW-1:0] k);
    logic [63:0] s;
    s = d >> {k, 4'b0000};
    return s[15:0];
  endfunction

  // Next-state logic. i_mode low overrides every transition, which gives
  // both the abort path and the DONE -> IDLE exit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bar_d   = bar_q;
    layer_d = layer_q;
    data_d  = data_q;
`ifdef SRAM_WRITE_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_mode) state_d = ARMED;
      end
      ARMED: begin
        if (i_start && i_mode) begin
          bar_d   = i_bar;
          layer_d = i_layer;
          data_d  = i_data;
          k_d     = '0;
`ifdef SRAM_WRITE_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: state_d = PULSE;
      PULSE: state_d = HOLD;
      HOLD: begin
        if (k_q != LAST_K) begin
          k_d     = k_q + 1'b1;
          state_d = SETUP;
        end else begin
`ifdef SRAM_WRITE_VERIFY_EN
          k_d     = '0;
          state_d = RSETUP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SRAM_WRITE_VERIFY_EN
      RSETUP: state_d = RCMP;
      RCMP: begin
        if (i_SRAM_DQ != word_of(data_q, k_q)) err_d = 1'b1;
        if (k_q != LAST_K) begin
          k_d     = k_q + 1'b1;
          state_d = RSETUP;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE: state_d = ARMED;
      default: state_d = IDLE;
    endcase
    if (!i_mode) state_d = IDLE;
  end

  // Output decode from the next state, so registered outputs line up with
  // the state they belong to. Address and data depend only on the latched
  // job and k, which keeps them stable across SETUP/PULSE/HOLD.
  always_comb begin
    write_ph = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
`ifdef SRAM_WRITE_VERIFY_EN
    read_ph  = (state_d == RSETUP) || (state_d == RCMP);
    addr_en  = write_ph || read_ph;
    oe_n_d   = !read_ph;
`else
    addr_en  = write_ph;
`endif
    addr_d   = addr_en ? (bar_base(bar_d, layer_d, WORDS_PER_BAR, LAYER_OFFSET)
                          + {{(20 - KW){1'b0}}, k_d}) : 20'd0;
    dq_d     = write_ph ? word_of(data_d, k_d) : 16'd0;
    dq_oe_d  = write_ph;
    we_n_d   = (state_d != PULSE);
    busy_d   = (state_d != IDLE) && (state_d != ARMED);
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      bar_q     <= '0;
      layer_q   <= 1'b0;
      data_q    <= '0;
      o_addr    <= '0;
      o_SRAM_DQ <= '0;
      o_dq_oe   <= 1'b0;
      o_we_n    <= 1'b1;
      o_busy    <= 1'b0;
      o_finish  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bar_q     <= bar_d;
      layer_q   <= layer_d;
      data_q    <= data_d;
      o_addr    <= addr_d;
      o_SRAM_DQ <= dq_d;
      o_dq_oe   <= dq_oe_d;
      o_we_n    <= we_n_d;
      o_busy    <= busy_d;
      o_finish  <= finish_d;
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  // The error flag is sticky for one job: cleared on an accepted start and
  // otherwise held, so it is still valid alongside and after o_finish.
  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      err_q  <= 1'b0;
      o_oe_n <= 1'b1;
    end else begin
      err_q  <= err_d;
      o_oe_n <= oe_n_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_sram_dq;
  assign unused_sram_dq = ^i_SRAM_DQ;
  assign o_oe_n = 1'b1;
  assign o_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sram_pattern_writer.sv
// tb_sram_pattern_writer: directed bench for sram_pattern_writer with a
// small SRAM model (writes on o_we_n low, combinational readback with an
// optional single-bit fault).
module tb_sram_pattern_writer;

`ifdef SRAM_WRITE_VERIFY_EN
  localparam int FIN_CYC = 21;
`else
  localparam int FIN_CYC = 13;
`endif

  logic        i_bclk;
  logic        i_rst;
  logic        i_mode;
  logic        i_start;
  logic [3:0]  i_bar;
  logic        i_layer;
  logic [63:0] i_data;
  logic [15:0] i_SRAM_DQ;
  logic [19:0] o_addr;
  logic [15:0] o_SRAM_DQ;
  logic        o_dq_oe;
  logic        o_we_n;
  logic        o_oe_n;
  logic        o_busy;
  logic        o_finish;
  logic        o_err;

  int vectors;
  int miscompares;

  logic [15:0] mem [0:255];
  logic        flip_en;
  logic [19:0] flip_addr;

  sram_pattern_writer dut (
    .i_bclk    (i_bclk),
    .i_rst     (i_rst),
    .i_mode    (i_mode),
    .i_start   (i_start),
    .i_bar     (i_bar),
    .i_layer   (i_layer),
    .i_data    (i_data),
    .i_SRAM_DQ (i_SRAM_DQ),
    .o_addr    (o_addr),
    .o_SRAM_DQ (o_SRAM_DQ),
    .o_dq_oe   (o_dq_oe),
    .o_we_n    (o_we_n),
    .o_oe_n    (o_oe_n),
    .o_busy    (o_busy),
    .o_finish  (o_finish),
    .o_err     (o_err)
  );

  initial i_bclk = 1'b0;
  always #5 i_bclk = ~i_bclk;

  // SRAM model: the write strobe is held for a full cycle, so capture on
  // the clock edge that ends PULSE.
  always @(posedge i_bclk) begin
    if (o_we_n == 1'b0) mem[o_addr[7:0]] <= o_SRAM_DQ;
  end

  always_comb begin
    i_SRAM_DQ = mem[o_addr[7:0]];
    if (flip_en && (o_addr == flip_addr)) i_SRAM_DQ[0] = ~i_SRAM_DQ[0];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one complete job from ARMED and checks every output on every
  // cycle up to the return to ARMED. restart_at != 0 pulses a conflicting
  // i_start in that cycle, which must be ignored.
  task automatic run_job(input string name, input logic [3:0] bar, input logic layer,
                         input logic [63:0] data, input logic [19:0] exp_base,
                         input int restart_at, input logic exp_err);
    int pulses;
    int finishes;
    int w;
    int ph;
    logic [63:0] sh;
    logic [19:0] e_addr;
    logic [15:0] e_dq;
    logic e_we_n, e_dq_oe, e_oe_n, e_busy, e_fin;
    pulses = 0;
    finishes = 0;
    @(negedge i_bclk);
    i_bar = bar; i_layer = layer; i_data = data; i_start = 1'b1;
    for (int cyc = 1; cyc <= FIN_CYC + 1; cyc++) begin
      @(negedge i_bclk);
      if (cyc == 1) i_start = 1'b0;
      e_addr = 20'd0; e_dq = 16'd0; e_we_n = 1'b1; e_dq_oe = 1'b0;
      e_oe_n = 1'b1; e_busy = 1'b1; e_fin = 1'b0;
      if (cyc <= 12) begin
        w = (cyc - 1) / 3;
        ph = (cyc - 1) % 3;
        sh = data >> (16 * w);
        e_addr = exp_base + 20'(w);
        e_dq = sh[15:0];
        e_we_n = (ph != 1);
        e_dq_oe = 1'b1;
      end else if (cyc < FIN_CYC) begin
        w = (cyc - 13) / 2;
        e_addr = exp_base + 20'(w);
        e_oe_n = 1'b0;
      end else if (cyc == FIN_CYC) begin
        e_fin = 1'b1;
      end else begin
        e_busy = 1'b0;
      end
      vectors += 7;
      if (o_addr !== e_addr) begin
        miscompares++;
        $display("[TB] FAIL %s addr cyc %0d: got %0d expected %0d", name, cyc, o_addr, e_addr);
      end
      if (o_SRAM_DQ !== e_dq) begin
        miscompares++;
        $display("[TB] FAIL %s dq cyc %0d: got %h expected %h", name, cyc, o_SRAM_DQ, e_dq);
      end
      if (o_we_n !== e_we_n) begin
        miscompares++;
        $display("[TB] FAIL %s we_n cyc %0d: got %b expected %b", name, cyc, o_we_n, e_we_n);
      end
      if (o_dq_oe !== e_dq_oe) begin
        miscompares++;
        $display("[TB] FAIL %s dq_oe cyc %0d: got %b expected %b", name, cyc, o_dq_oe, e_dq_oe);
      end
      if (o_oe_n !== e_oe_n) begin
        miscompares++;
        $display("[TB] FAIL %s oe_n cyc %0d: got %b expected %b", name, cyc, o_oe_n, e_oe_n);
      end
      if (o_busy !== e_busy) begin
        miscompares++;
        $display("[TB] FAIL %s busy cyc %0d: got %b expected %b", name, cyc, o_busy, e_busy);
      end
      if (o_finish !== e_fin) begin
        miscompares++;
        $display("[TB] FAIL %s finish cyc %0d: got %b expected %b", name, cyc, o_finish, e_fin);
      end
      if (cyc == FIN_CYC) begin
        vectors++;
        if (o_err !== exp_err) begin
          miscompares++;
          $display("[TB] FAIL %s err: got %b expected %b", name, o_err, exp_err);
        end
      end
      if (o_we_n === 1'b0) pulses++;
      if (o_finish === 1'b1) finishes++;
      if (restart_at != 0 && cyc == restart_at) begin
        i_start = 1'b1; i_bar = ~bar; i_layer = ~layer; i_data = ~data;
      end
      if (restart_at != 0 && cyc == restart_at + 1) i_start = 1'b0;
    end
    vectors += 2;
    if (pulses != 4) begin
      miscompares++;
      $display("[TB] FAIL %s we pulses: got %0d expected 4", name, pulses);
    end
    if (finishes != 1) begin
      miscompares++;
      $display("[TB] FAIL %s finish count: got %0d expected 1", name, finishes);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_mode = 1'b0; i_start = 1'b0; i_bar = 4'd0; i_layer = 1'b0; i_data = 64'd0;
    repeat (2) @(negedge i_bclk);
    vectors += 8;
    if (o_addr !== 20'd0)     begin miscompares++; $display("[TB] FAIL reset addr: got %0d expected 0", o_addr); end
    if (o_SRAM_DQ !== 16'd0)  begin miscompares++; $display("[TB] FAIL reset dq: got %h expected 0", o_SRAM_DQ); end
    if (o_dq_oe !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset dq_oe: got %b expected 0", o_dq_oe); end
    if (o_we_n !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset we_n: got %b expected 1", o_we_n); end
    if (o_oe_n !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset oe_n: got %b expected 1", o_oe_n); end
    if (o_busy !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset busy: got %b expected 0", o_busy); end
    if (o_finish !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset finish: got %b expected 0", o_finish); end
    if (o_err !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset err: got %b expected 0", o_err); end
    i_rst = 1'b1;
    @(negedge i_bclk);
    i_mode = 1'b1;
    @(negedge i_bclk);
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL armed busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_write_layer0();
    run_job("layer0", 4'd2, 1'b0, 64'h0123_4567_89AB_CDEF, 20'd12, 0, 1'b0);
    vectors += 4;
    if (mem[12] !== 16'hCDEF) begin miscompares++; $display("[TB] FAIL mem12: got %h expected cdef", mem[12]); end
    if (mem[13] !== 16'h89AB) begin miscompares++; $display("[TB] FAIL mem13: got %h expected 89ab", mem[13]); end
    if (mem[14] !== 16'h4567) begin miscompares++; $display("[TB] FAIL mem14: got %h expected 4567", mem[14]); end
    if (mem[15] !== 16'h0123) begin miscompares++; $display("[TB] FAIL mem15: got %h expected 0123", mem[15]); end
  endtask

  task automatic test_layer1();
    run_job("bar15_layer1", 4'd15, 1'b1, 64'hFEDC_BA98_7654_3210, 20'd128, 0, 1'b0);
    run_job("bar0_layer1", 4'd0, 1'b1, 64'h1111_2222_3333_4444, 20'd68, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_job("busy_start", 4'd7, 1'b0, 64'hA5A5_5A5A_F00F_0FF0, 20'd32, 5, 1'b0);
  endtask

  task automatic test_abort();
    int fin_seen;
    fin_seen = 0;
    @(negedge i_bclk);
    i_bar = 4'd5; i_layer = 1'b0; i_data = 64'hDDDD_CCCC_BBBB_AAAA; i_start = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge i_bclk);
      if (cyc == 1) i_start = 1'b0;
      if (o_finish === 1'b1) fin_seen++;
    end
    vectors++;
    if (o_addr !== 20'd26) begin miscompares++; $display("[TB] FAIL abort hold addr: got %0d expected 26", o_addr); end
    i_mode = 1'b0;
    @(negedge i_bclk);
    vectors += 3;
    if (o_busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL abort busy: got %b expected 0", o_busy); end
    if (o_we_n !== 1'b1)  begin miscompares++; $display("[TB] FAIL abort we_n: got %b expected 1", o_we_n); end
    if (o_dq_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL abort dq_oe: got %b expected 0", o_dq_oe); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge i_bclk);
      if (o_finish === 1'b1) fin_seen++;
    end
    vectors += 3;
    if (fin_seen != 0)         begin miscompares++; $display("[TB] FAIL abort finish: got %0d expected 0", fin_seen); end
    if (mem[26] !== 16'hCCCC)  begin miscompares++; $display("[TB] FAIL abort mem26: got %h expected cccc", mem[26]); end
    if (mem[27] !== 16'h0000)  begin miscompares++; $display("[TB] FAIL abort mem27: got %h expected 0000", mem[27]); end
    i_mode = 1'b1;
    @(negedge i_bclk);
  endtask

  task automatic test_reset_midwrite();
    @(negedge i_bclk);
    i_bar = 4'd3; i_layer = 1'b0; i_data = 64'h9999_8888_7777_6666; i_start = 1'b1;
    @(negedge i_bclk);
    i_start = 1'b0;
    @(negedge i_bclk);
    vectors++;
    if (o_we_n !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst pulse we_n: got %b expected 0", o_we_n); end
    #1 i_rst = 1'b0;
    #1;
    vectors += 6;
    if (o_we_n !== 1'b1)     begin miscompares++; $display("[TB] FAIL midrst we_n: got %b expected 1", o_we_n); end
    if (o_addr !== 20'd0)    begin miscompares++; $display("[TB] FAIL midrst addr: got %0d expected 0", o_addr); end
    if (o_SRAM_DQ !== 16'd0) begin miscompares++; $display("[TB] FAIL midrst dq: got %h expected 0", o_SRAM_DQ); end
    if (o_dq_oe !== 1'b0)    begin miscompares++; $display("[TB] FAIL midrst dq_oe: got %b expected 0", o_dq_oe); end
    if (o_busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL midrst busy: got %b expected 0", o_busy); end
    if (o_finish !== 1'b0)   begin miscompares++; $display("[TB] FAIL midrst finish: got %b expected 0", o_finish); end
    @(negedge i_bclk);
    i_rst = 1'b1; i_start = 1'b1;
    @(negedge i_bclk);
    i_start = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst idle: got busy %b expected 0", o_busy); end
    @(negedge i_bclk);
  endtask

`ifdef SRAM_WRITE_VERIFY_EN
  task automatic test_verify();
    flip_en = 1'b1; flip_addr = 20'd11;
    run_job("verify_bad", 4'd1, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 20'd8, 0, 1'b1);
    flip_en = 1'b0;
    run_job("verify_clean", 4'd1, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 20'd8, 0, 1'b0);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    flip_en = 1'b0;
    flip_addr = 20'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    test_reset();
    test_write_layer0();
    test_layer1();
    test_start_while_busy();
    test_abort();
    test_reset_midwrite();
`ifdef SRAM_WRITE_VERIFY_EN
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
